// File: rtl/amba_master.sv
// AHB-Lite style initiator: one 128-bit single transfer per command, one response per command.
// Optional data-phase watchdog is enabled by defining AMBA_MASTER_TIMEOUT_EN.
module amba_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [127:0]      cmd_wdata,
  output logic              rsp_valid,
  output logic [127:0]      rsp_rdata,
  output logic              rsp_error,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [127:0]      HWDATA,
  input  logic [127:0]      HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e        state_q;
  logic [127:0]  wdata_q;

`ifdef AMBA_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);
  logic [CntW-1:0] tmo_cnt_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  // Every transfer is a full 128-bit beat.
  assign HSIZE = 3'b100;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      HADDR     <= '0;
      HTRANS    <= TransIdle;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
      wdata_q   <= '0;
`ifdef AMBA_MASTER_TIMEOUT_EN
      rsp_timeout <= 1'b0;
      tmo_cnt_q   <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            state_q   <= StAddr;
            cmd_ready <= 1'b0;
            HTRANS    <= TransNonseq;
            // Beat-aligned address: low nibble is always zero for 128-bit transfers.
            HADDR     <= cmd_addr & ~ADDR_W'(4'hF);
            HWRITE    <= cmd_write;
            wdata_q   <= cmd_wdata;
          end
        end
        StAddr: begin
          if (HREADY) begin
            state_q <= StData;
            HTRANS  <= TransIdle;
            HWDATA  <= HWRITE ? wdata_q : '0;
`ifdef AMBA_MASTER_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end
        end
        StData: begin
          // Completion outranks the watchdog when both land on the same cycle.
          if (HREADY) begin
            state_q   <= StResp;
            rsp_valid <= 1'b1;
            rsp_rdata <= HWRITE ? '0 : HRDATA;
            rsp_error <= HRESP;
            HWDATA    <= '0;
`ifdef AMBA_MASTER_TIMEOUT_EN
            rsp_timeout <= 1'b0;
          end else if (tmo_cnt_q == CntMax) begin
            state_q     <= StResp;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b1;
            rsp_timeout <= 1'b1;
            HWDATA      <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
          end
        end
        StResp: begin
          state_q   <= StIdle;
          cmd_ready <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_amba_master.sv
// Randomized bench for amba_master: a transaction-level schedule model predicts every output
// per cycle; a negedge process compares, plus literal pins for the documented scenarios.
module tb_amba_master;

  localparam int unsigned AW = 32;
  localparam int unsigned TO = 4;
`ifdef AMBA_MASTER_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]  cmd_addr;
  logic [127:0]   cmd_wdata;
  logic           rsp_valid, rsp_error, rsp_timeout;
  logic [127:0]   rsp_rdata;
  logic [AW-1:0]  HADDR;
  logic [1:0]     HTRANS;
  logic           HWRITE;
  logic [2:0]     HSIZE;
  logic [127:0]   HWDATA, HRDATA;
  logic           HREADY, HRESP;

  amba_master #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .rsp_timeout(rsp_timeout),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int last_rsp_cyc = 0;
  int acc_cyc = 0;

  // Model expectations for the current cycle
  logic           chk_en = 1'b0;
  logic           chk_addr = 1'b0;
  logic           exp_cmd_ready = 1'b1, exp_rsp_valid = 1'b0;
  logic [127:0]   exp_rsp_rdata = '0;
  logic           exp_rsp_error = 1'b0, exp_rsp_timeout = 1'b0;
  logic [1:0]     exp_htrans = 2'b00;
  logic [127:0]   exp_hwdata = '0;
  logic [AW-1:0]  exp_haddr = '0;
  logic           exp_hwrite = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cyc_n++;
    if (rsp_valid === 1'b1) last_rsp_cyc = cyc_n;
    if (chk_en) begin
      chk("cmd_ready", 128'(cmd_ready), 128'(exp_cmd_ready));
      chk("rsp_valid", 128'(rsp_valid), 128'(exp_rsp_valid));
      chk("rsp_rdata", rsp_rdata, exp_rsp_rdata);
      chk("rsp_error", 128'(rsp_error), 128'(exp_rsp_error));
      chk("rsp_timeout", 128'(rsp_timeout), 128'(exp_rsp_timeout));
      chk("htrans", 128'(HTRANS), 128'(exp_htrans));
      chk("hsize", 128'(HSIZE), 128'(3'b100));
      chk("hwdata", HWDATA, exp_hwdata);
      if (chk_addr) begin
        chk("haddr", 128'(HADDR), 128'(exp_haddr));
        chk("hwrite", 128'(HWRITE), 128'(exp_hwrite));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic exp_idle();
    exp_cmd_ready = 1'b1;
    exp_rsp_valid = 1'b0;
    exp_htrans    = 2'b00;
    exp_hwdata    = '0;
    chk_addr      = 1'b0;
  endtask

  task automatic exp_reset();
    exp_idle();
    exp_rsp_rdata   = '0;
    exp_rsp_error   = 1'b0;
    exp_rsp_timeout = 1'b0;
    chk_addr        = 1'b1;
    exp_haddr       = '0;
    exp_hwrite      = 1'b0;
  endtask

  task automatic set_addr_phase(input logic w, input logic [AW-1:0] addr);
    exp_cmd_ready = 1'b0;
    exp_rsp_valid = 1'b0;
    exp_htrans    = 2'b10;
    exp_hwdata    = '0;
    chk_addr      = 1'b1;
    exp_haddr     = addr & ~AW'(4'hF);
    exp_hwrite    = w;
  endtask

  task automatic set_data_phase(input logic w, input logic [127:0] wd);
    exp_cmd_ready = 1'b0;
    exp_rsp_valid = 1'b0;
    exp_htrans    = 2'b00;
    exp_hwdata    = w ? wd : '0;
    chk_addr      = 1'b0;
  endtask

  // One command: a = address-phase wait cycles, d = data-phase HREADY-low cycles.
  task automatic run_txn(input logic w, input logic [AW-1:0] addr, input logic [127:0] wd,
                         input int a, input int d, input logic err, input logic [127:0] rd,
                         input logic hold, input int idle);
    bit to;
    int lows;
    for (int i = 0; i < idle; i++) begin
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = $urandom;
      HREADY    = 1'($urandom);
      HRESP     = 1'($urandom);
      exp_idle();
      tick();
    end
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = addr;
    cmd_wdata = wd;
    HREADY    = 1'($urandom);
    exp_idle();
    acc_cyc = cyc_n + 1;
    tick();
    for (int i = 0; i <= a; i++) begin
      cmd_valid = hold;
      cmd_write = ~w;
      cmd_addr  = $urandom;
      cmd_wdata = rand128();
      HREADY    = (i == a);
      HRESP     = 1'($urandom);
      set_addr_phase(w, addr);
      tick();
    end
    to   = TmoEn && (d > int'(TO));
    lows = to ? int'(TO) + 1 : d;
    for (int j = 0; j < (to ? lows : lows + 1); j++) begin
      cmd_valid = hold;
      HREADY    = !to && (j == lows);
      HRESP     = !to && err && (j + 1 >= lows);
      HRDATA    = (j == lows) ? rd : rand128();
      set_data_phase(w, wd);
      tick();
    end
    cmd_valid       = hold;
    HREADY          = 1'($urandom);
    HRESP           = 1'($urandom);
    HRDATA          = rand128();
    exp_cmd_ready   = 1'b0;
    exp_rsp_valid   = 1'b1;
    exp_rsp_rdata   = (to || w) ? '0 : rd;
    exp_rsp_error   = to ? 1'b1 : err;
    exp_rsp_timeout = to;
    exp_htrans      = 2'b00;
    exp_hwdata      = '0;
    chk_addr        = 1'b0;
    tick();
    cmd_valid = 1'b0;
    exp_idle();
  endtask

  int prev_rsp;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_reset();
    chk_en = 1'b1;
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("rst_htrans", 128'(HTRANS), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    tick();

    // Zero-wait write
    run_txn(1'b1, 32'h0000_1004, {16{8'hA5}}, 0, 0, 1'b0, '0, 1'b0, 0);
    chk("lit_wr_latency", 128'(last_rsp_cyc - acc_cyc), 128'(3));
    chk("lit_wr_error", 128'(rsp_error), 128'(0));

    // Read with three data-phase wait states
    run_txn(1'b0, 32'h0000_0020, '0, 0, 3, 1'b0,
            128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 1'b0, 1);
    chk("lit_rd_latency", 128'(last_rsp_cyc - acc_cyc), 128'(6));
    chk("lit_rd_data", rsp_rdata, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF);

    // Two-cycle error response
    run_txn(1'b0, 32'h0000_0040, '0, 0, 1, 1'b1, rand128(), 1'b0, 1);
    chk("lit_err_error", 128'(rsp_error), 128'(1));
    chk("lit_err_timeout", 128'(rsp_timeout), 128'(0));

    if (TmoEn) begin
      run_txn(1'b0, 32'h0000_0080, '0, 0, 20, 1'b0, rand128(), 1'b0, 1);
      chk("lit_tmo_latency", 128'(last_rsp_cyc - acc_cyc), 128'(7));
      chk("lit_tmo_flags", 128'({rsp_error, rsp_timeout}), 128'(2'b11));
    end

    // Reset during the data phase of a write
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0300; cmd_wdata = rand128();
    exp_idle();
    tick();
    cmd_valid = 1'b0; HREADY = 1'b1;
    set_addr_phase(1'b1, 32'h0000_0300);
    tick();
    HREADY = 1'b0;
    set_data_phase(1'b1, cmd_wdata);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_reset();
    chk("lit_rst_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("lit_rst_htrans", 128'(HTRANS), 128'(0));
    tick();
    tick();
    run_txn(1'b0, 32'h0000_0510, '0, 1, 1, 1'b0, rand128(), 1'b0, 0);

    // Back-to-back with cmd_valid held high
    run_txn(1'b1, 32'h0000_0600, rand128(), 0, 0, 1'b0, '0, 1'b1, 0);
    prev_rsp = last_rsp_cyc;
    run_txn(1'b0, 32'h0000_0610, '0, 0, 0, 1'b0, rand128(), 1'b1, 0);
    chk("lit_b2b_spacing", 128'(last_rsp_cyc - prev_rsp), 128'(4));

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      run_txn(1'($urandom), $urandom, rand128(), int'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9))
                                          : int'($urandom_range(0, 2)),
              1'($urandom), rand128(), 1'($urandom), int'($urandom_range(0, 2)));
    end
    tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/amba_master.md
# amba_master

AHB-Lite style bus initiator that issues single 128-bit read or write transfers on behalf of a local requester. It is the initiating end of the same 128-bit AMBA interface our subordinate blocks answer on: drives HADDR/HTRANS/HWRITE/HSIZE/HWDATA, samples HRDATA/HREADY/HRESP. It returns one response per command. One transfer is outstanding at a time; there is no address/data pipelining across commands.

## Interface
Parameters:
- ADDR_W, 32, bus address width
- TIMEOUT_CYCLES, 16, consecutive HREADY-low data-phase cycles before abort (only with AMBA_MASTER_TIMEOUT_EN)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  128  write data
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  128  read data (0 for writes)
- rsp_error  out  1  transfer ended with HRESP error or timeout
- rsp_timeout  out  1  transfer aborted by watchdog
- HADDR  out  ADDR_W  bus address
- HTRANS  out  2  2'b00 IDLE, 2'b10 NONSEQ
- HWRITE  out  1  transfer direction
- HSIZE  out  3  constant 3'b100 (128-bit)
- HWDATA  out  128  write data, valid in data phase
- HRDATA  in  128  read data
- HREADY  in  1  subordinate ready
- HRESP  in  1  0 OKAY, 1 ERROR

## Operation
- States: IDLE, ADDR, DATA, RESP.
- IDLE: cmd_ready=1, HTRANS=00. On cmd_valid: latch cmd_write/cmd_addr/cmd_wdata, go ADDR.
- ADDR: HTRANS=10, HADDR=latched address with [3:0] forced to 0, HWRITE=latched direction. If HREADY=1 go DATA, else hold ADDR with all address-phase outputs stable.
- DATA: HTRANS=00; HWDATA=latched data when write (held stable until completion), 0 otherwise. Completes on HREADY=1: capture HRDATA (reads) and HRESP into rsp_rdata/rsp_error, go RESP.
- Error handling: HRESP=1 with HREADY=0 is the first error cycle; keep waiting. Completion cycle (HREADY=1) with HRESP=1 sets rsp_error=1.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE unconditionally. rsp_rdata/rsp_error/rsp_timeout hold their values until the next RESP.
- cmd_valid outside IDLE is ignored. Commands are not queued.

## Timing
- Reset values: state IDLE, cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, rsp_timeout=0, HADDR=0, HTRANS=00, HWRITE=0, HWDATA=0, HSIZE=100.
- Zero-wait-state latency: command accepted at edge 0, ADDR cycle 1, DATA cycle 2, rsp_valid high cycle 3, cmd_ready high again cycle 4. Each HREADY-low cycle in ADDR or DATA adds one cycle.
- Outputs are registered. No combinational path from H* inputs to any output.
- rst asserted in any state: next edge returns all outputs to reset values. An in-flight transfer is abandoned and no response is issued.

## Configuration
- AMBA_MASTER_TIMEOUT_EN defined: a counter (width clog2(TIMEOUT_CYCLES+1)) clears on entry to DATA and increments on each DATA cycle with HREADY=0. When it reaches TIMEOUT_CYCLES, go RESP with rsp_error=1, rsp_timeout=1, rsp_rdata=0. HTRANS is already IDLE. A completion on that same cycle (HREADY=1) takes priority over the timeout.
- Undefined: no counter. DATA waits indefinitely. rsp_timeout is tied 0.

## Test plan
- Write addr 0x0000_1004, data 0xA5..A5, zero wait: HTRANS=10/HADDR=0x0000_1000/HWRITE=1 in cycle 1, HWDATA=0xA5..A5 in cycle 2, rsp_valid cycle 3, rsp_error=0.
- Read addr 0x20, subordinate holds HREADY=0 for 3 data cycles, then returns HRDATA=0x0123..CDEF: rsp_valid in cycle 6 with rsp_rdata=0x0123..CDEF, HWDATA=0 throughout.
- Two-cycle error response (HRESP=1/HREADY=0, then HRESP=1/HREADY=1) on read: rsp_valid with rsp_error=1, rsp_timeout=0.
- With AMBA_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, HREADY held 0 in DATA: rsp_valid 5 cycles after entering DATA, rsp_error=1, rsp_timeout=1, cmd_ready=1 the following cycle.
- rst pulsed during DATA of a write: next cycle HTRANS=00, cmd_ready=1, no rsp_valid. A following read completes normally.
- cmd_valid held high across back-to-back commands: accepted only in IDLE, one rsp_valid per accepted command, 4-cycle spacing at zero wait states.
